// File: rtl/fifo_cdcc_pkg.sv
// Shared definitions for the FIFO write-side arbitration logic.
// Holds the arbiter state encodings used by fifo_write_arbiter.
package fifo_cdcc_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_BURST = ST_BURST
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first set request bit found
// searching upward from (i_last_idx + 1) mod INT_REQUESTERS.
module rr_priority_picker #(
  parameter int INT_REQUESTERS = 4,
  parameter int INT_IDX_BITS   = $clog2(INT_REQUESTERS)
) (
  input  logic [INT_REQUESTERS-1:0] i_req,
  input  logic [INT_IDX_BITS-1:0]   i_last_idx,
  output logic [INT_REQUESTERS-1:0] o_onehot,
  output logic [INT_IDX_BITS-1:0]   o_idx,
  output logic                      o_any
);

  // Walk all requesters once, starting just after the last grantee
  always_comb begin
    int                    v_pos;
    logic [INT_IDX_BITS-1:0] v_idx;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    v_pos    = 0;
    v_idx    = '0;
    for (int k = 1; k <= INT_REQUESTERS; k++) begin
      v_pos = (int'(i_last_idx) + k) % INT_REQUESTERS;
      v_idx = INT_IDX_BITS'(v_pos);
      if (!o_any && i_req[v_idx]) begin
        o_any           = 1'b1;
        o_idx           = v_idx;
        o_onehot[v_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter in front of the FIFO write controller.
// One requester owns the write port until its last beat or the burst cap.
module fifo_write_arbiter
  import fifo_cdcc_pkg::*;
#(
  parameter int INT_REQUESTERS = 4,
  parameter int INT_DATA_BITS  = 32,
  parameter int INT_MAX_BURST  = 16
) (
  input  logic                                    wr_clk,
  input  logic                                    wr_rst,
  input  logic [INT_REQUESTERS-1:0]               i_valid,
  input  logic [INT_REQUESTERS-1:0]               i_last,
  input  logic [INT_REQUESTERS*INT_DATA_BITS-1:0] i_data,
  output logic [INT_REQUESTERS-1:0]               o_ready,
  output logic                                    o_valid,
  output logic [INT_DATA_BITS-1:0]                o_data,
  output logic                                    o_last,
  output logic [$clog2(INT_REQUESTERS)-1:0]       o_src_id,
  input  logic                                    i_ready,
  output logic [INT_REQUESTERS-1:0]               o_grant,
  output logic                                    o_trunc
);

  localparam int ID_W  = $clog2(INT_REQUESTERS);
  localparam int CNT_W = $clog2(INT_MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INT_MAX_BURST);
  localparam logic [ID_W-1:0]  ID_END  = ID_W'(INT_REQUESTERS - 1);

  arb_state_e                r_state;
  logic [INT_REQUESTERS-1:0] r_grant;
  logic [ID_W-1:0]           r_src_id;
  logic [ID_W-1:0]           r_last_gnt;
  logic [CNT_W-1:0]          r_cnt;

  logic [INT_REQUESTERS-1:0] w_pick_oh;
  logic [ID_W-1:0]           w_pick_idx;
  logic                      w_pick_any;
  logic [INT_DATA_BITS-1:0]  w_data;
  logic                      w_valid;
  logic                      w_last;
  logic                      w_beat;
  logic                      w_at_max;
  logic [CNT_W-1:0]          w_cnt_nxt;

  rr_priority_picker #(
    .INT_REQUESTERS (INT_REQUESTERS),
    .INT_IDX_BITS   (ID_W)
  ) u_picker (
    .i_req      (i_valid),
    .i_last_idx (r_last_gnt),
    .o_onehot   (w_pick_oh),
    .o_idx      (w_pick_idx),
    .o_any      (w_pick_any)
  );

  // AND-OR mux of the granted lane; grant is all-zero in IDLE
  always_comb begin
    w_data  = '0;
    w_valid = 1'b0;
    w_last  = 1'b0;
    for (int k = 0; k < INT_REQUESTERS; k++) begin
      if (r_grant[k]) begin
        w_data  |= i_data[k*INT_DATA_BITS +: INT_DATA_BITS];
        w_valid |= i_valid[k];
        w_last  |= i_last[k];
      end
    end
  end

  assign w_beat    = (r_state == S_BURST) && w_valid && i_ready;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_at_max  = (w_cnt_nxt == CNT_MAX);

  assign o_valid  = w_valid;
  assign o_data   = w_data;
  assign o_last   = w_last;
  assign o_grant  = r_grant;
  assign o_src_id = r_src_id;
  assign o_ready  = wr_rst ? '0 : (r_grant & {INT_REQUESTERS{i_ready}});
  assign o_trunc  = w_beat && w_at_max && !w_last;

  // Grant/burst FSM: arbitrate in IDLE, hold grant until last or cap
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_src_id   <= '0;
      r_last_gnt <= ID_END;
      r_cnt      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pick_any) begin
            r_state    <= S_BURST;
            r_grant    <= w_pick_oh;
            r_src_id   <= w_pick_idx;
            r_last_gnt <= w_pick_idx;
            r_cnt      <= '0;
          end
        end
        S_BURST: begin
          if (w_beat) begin
            if (w_last || w_at_max) begin
              r_state  <= S_IDLE;
              r_grant  <= '0;
              r_src_id <= '0;
              r_cnt    <= '0;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
